// File: rtl/alu_mul_seq.sv
//------------------------------------------------------------------------------
// alu_mul_seq
//------------------------------------------------------------------------------
// Purpose:
//   Multi-cycle unsigned 32x32 multiply sequencer. It has no multiplier array of
//   its own. It borrows the shared 32-bit ALU for one add per multiplier bit
//   (shift-add, always 32 iterations), and it owns the ALU only while it runs.
//
//   Timing: the operands are accepted on the edge at cycle 0. RUN covers cycles
//   1..32. The result is valid from cycle 33 and is held until the consumer
//   takes it.
//
// Optional feature (macro SEQ_MULHI_EN):
//   When defined, the add carry is recovered from the ALU result with an
//   unsigned compare, and res_hi presents product[63:32].
//   When undefined, the carry is tied low and res_hi is constant 0.
//   res_lo is exact in both builds, because the carries only ever enter at
//   bit 63 and shift right by at most 31 places.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start_valid  in   1   request to multiply op_a*op_b
//   start_ready  out  1   sequencer idle, can accept
//   op_a         in  32   multiplicand
//   op_b         in  32   multiplier
//   abort        in   1   synchronous cancel of the running operation
//   res_valid    out  1   result available
//   res_ready    in   1   consumer accepts result
//   res_lo       out 32   product[31:0]
//   res_hi       out 32   product[63:32] (0 unless SEQ_MULHI_EN)
//   alu_own      out  1   sequencer drives the ALU this cycle
//   alu_a        out 32   ALU operand A
//   alu_b        out 32   ALU operand B
//   alu_sel      out  4   ALU select code
//   alu_cin      out  1   ALU carry-in
//   alu_res      in  32   ALU result, combinational from alu_a/alu_b
//------------------------------------------------------------------------------
module alu_mul_seq #(
    parameter logic [3:0] SEL_ADD = 4'd0,
    parameter logic       CIN_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        abort,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_lo,
    output logic [31:0] res_hi,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic        alu_cin,
    input  logic [31:0] alu_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [63:0] r_p;          // {partial-product high half, remaining multiplier bits}
    logic [5:0]  r_cnt;
    logic [31:0] r_res_lo;

    logic [31:0] w_hi;
    logic        w_add;
    logic [31:0] w_sum;
    logic        w_carry;
    logic [63:0] w_p_next;
    logic        w_run;

    assign w_hi  = r_p[63:32];
    assign w_add = r_p[0];
    assign w_run = (r_state == ST_RUN);

    // Add the multiplicand only when the current multiplier bit is set;
    // otherwise the high half passes through untouched.
    assign w_sum = w_add ? alu_res : w_hi;

`ifdef SEQ_MULHI_EN
    // The ALU is only 32 bits wide, so the carry-out is recovered afterwards:
    // an unsigned sum that wrapped is smaller than either of its addends.
    assign w_carry = w_add & (alu_res < w_hi);
`else
    assign w_carry = 1'b0;
`endif

    // The carry enters at bit 63 and the whole register shifts right by one.
    assign w_p_next = {w_carry, w_sum, r_p[31:1]};

    //--------------------------------------------------------------------------
    // Sequencer FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_res_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // An abort in the same cycle suppresses the request.
                    if (!abort && start_valid) begin
                        r_mcand <= op_a;
                        r_p     <= {32'h0, op_b};
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_p   <= w_p_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            // The result is captured separately so that it
                            // survives the return to IDLE unchanged.
                            r_res_lo <= w_p_next[31:0];
                            r_state  <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // abort wins over res_ready. Either one releases the result.
                    if (abort || res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_MULHI_EN
    logic [31:0] r_res_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_hi <= '0;
        end else if (w_run && !abort && (r_cnt == 6'd31)) begin
            r_res_hi <= w_p_next[63:32];
        end
    end

    assign res_hi = r_res_hi;
`else
    assign res_hi = 32'h0;
`endif

    //--------------------------------------------------------------------------
    // Outputs: decoded from registered state only, so that an asynchronous
    // reset clears them immediately. Outside RUN the ALU-facing outputs are
    // forced to zero, so the main datapath sees the ALU untouched.
    //--------------------------------------------------------------------------
    assign start_ready = (r_state == ST_IDLE);
    assign res_valid   = (r_state == ST_DONE);
    assign res_lo      = r_res_lo;

    assign alu_own = w_run;
    assign alu_a   = w_run ? w_hi    : 32'h0;
    assign alu_b   = w_run ? r_mcand : 32'h0;
    assign alu_sel = w_run ? SEL_ADD : 4'd0;
    assign alu_cin = w_run ? CIN_ADD : 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
`timescale 1ns/1ps
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic        alu_cin;
    logic [31:0] alu_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: select code 0 adds with carry-in, and any
    // other code returns a different value so that a wrong select is visible.
    always_comb begin
        if (alu_sel == 4'd0) alu_res = alu_a + alu_b + {31'd0, alu_cin};
        else                 alu_res = ~(alu_a + alu_b);
    end

    alu_mul_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .abort       (abort),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_lo      (res_lo),
        .res_hi      (res_hi),
        .alu_own     (alu_own),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_cin     (alu_cin),
        .alu_res     (alu_res)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the full-width product from plain arithmetic.
    function automatic logic [31:0] exp_lo(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        return full[31:0];
    endfunction

    function automatic logic [31:0] exp_hi(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
`ifdef SEQ_MULHI_EN
        return full[63:32];
`else
        return 32'h0 & full[63:32];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_start_ready"}, {63'd0, start_ready}, 64'd1);
        chk({tag, "_res_valid"},   {63'd0, res_valid},   64'd0);
        chk({tag, "_res_lo"},      {32'd0, res_lo},      64'd0);
        chk({tag, "_res_hi"},      {32'd0, res_hi},      64'd0);
        chk({tag, "_alu_own"},     {63'd0, alu_own},     64'd0);
        chk({tag, "_alu_abcs"},    {alu_a, alu_b} | {59'd0, alu_sel, alu_cin}, 64'd0);
    endtask

    // Issue one operation from IDLE. Measure the latency and the number of
    // cycles in which the ALU is driven. Hold off the consumer for 'hold'
    // cycles while a competing request is presented, then take the result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
        int lat;
        int own_cnt;
        logic [31:0] el;
        logic [31:0] eh;
        el = exp_lo(a, b);
        eh = exp_hi(a, b);
        chk({tag, "_idle_ready"}, {63'd0, start_ready}, 64'd1);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        tick();
        start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        lat = 1;
        own_cnt = 0;
        while (res_valid !== 1'b1 && lat < 100) begin
            if (alu_own === 1'b1 && alu_sel === 4'd0 && alu_cin === 1'b0 && alu_b === a)
                own_cnt++;
            tick();
            lat++;
        end
        chk({tag, "_latency"},   lat,     64'd33);
        chk({tag, "_run_owned"}, own_cnt, 64'd32);
        chk({tag, "_done_own"},  {63'd0, alu_own}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            op_a = $urandom;
            op_b = $urandom;
            tick();
            chk({tag, "_hold_valid"}, {63'd0, res_valid},   64'd1);
            chk({tag, "_hold_ready"}, {63'd0, start_ready}, 64'd0);
            chk({tag, "_hold_lo"},    {32'd0, res_lo},      {32'd0, el});
        end
        start_valid = 1'b0;
        chk({tag, "_res_lo"}, {32'd0, res_lo}, {32'd0, el});
        chk({tag, "_res_hi"}, {32'd0, res_hi}, {32'd0, eh});
        $display("op %s: a=0x%08h b=0x%08h lo=0x%08h hi=0x%08h", tag, a, b, res_lo, res_hi);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_after_valid"}, {63'd0, res_valid},   64'd0);
        chk({tag, "_after_ready"}, {63'd0, start_ready}, 64'd1);
        chk({tag, "_after_lo"},    {32'd0, res_lo},      {32'd0, el});
    endtask

    initial begin
        int seen_valid;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op_a        = '0;
        op_b        = '0;
        abort       = 1'b0;
        res_ready   = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases
        do_op(32'd3, 32'd5, 0, "3x5");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "max_x_max");
        do_op(32'h12345678, 32'h0, 0, "x_zero");
        do_op(32'h0, 32'hFFFFFFFF, 0, "zero_x_max");
        do_op(32'hDEADBEEF, 32'h00000002, 10, "backpressure");

        // abort in IDLE beats start_valid
        abort = 1'b1;
        start_valid = 1'b1;
        op_a = 32'd4;
        op_b = 32'd4;
        tick();
        abort = 1'b0;
        start_valid = 1'b0;
        chk("idle_abort_ready", {63'd0, start_ready}, 64'd1);
        chk("idle_abort_own",   {63'd0, alu_own},     64'd0);

        // abort at RUN cycle 12
        start_valid = 1'b1;
        op_a = 32'hCAFEF00D;
        op_b = 32'h01234567;
        tick();
        start_valid = 1'b0;
        repeat (11) tick();
        chk("abort_in_run_own", {63'd0, alu_own}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_ready", {63'd0, start_ready}, 64'd1);
        chk("abort_run_own",   {63'd0, alu_own},     64'd0);
        seen_valid = 0;
        repeat (40) begin
            tick();
            if (res_valid === 1'b1) seen_valid++;
        end
        chk("abort_never_valid", seen_valid, 64'd0);
        $display("abort at RUN cycle 12 checked");
        do_op(32'd7, 32'd9, 0, "7x9");

        // abort and res_ready together in DONE: abort wins, result dropped
        start_valid = 1'b1;
        op_a = 32'd11;
        op_b = 32'd13;
        tick();
        start_valid = 1'b0;
        repeat (32) tick();
        chk("done_abort_pre_valid", {63'd0, res_valid}, 64'd1);
        abort = 1'b1;
        res_ready = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b0;
        chk("done_abort_valid", {63'd0, res_valid},   64'd0);
        chk("done_abort_ready", {63'd0, start_ready}, 64'd1);
        $display("abort in DONE checked");

        // Randomized operations against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i == 0) rb = 32'h80000001;
            do_op(ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        // Asynchronous reset at RUN cycle 20
        start_valid = 1'b1;
        op_a = 32'h55555555;
        op_b = 32'hAAAAAAAA;
        tick();
        start_valid = 1'b0;
        repeat (19) tick();
        chk("pre_reset_own", {63'd0, alu_own}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("async reset mid-RUN checked");
        do_op(32'd2, 32'h80000000, 0, "2x80000000");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
